// File: rtl/soc_system_dipsw_debounce_pio_pkg.sv
// Shared definitions for the DIP-switch input PIO: register map, edge-type
// encodings (also used by the companion output PIO) and edge qualification.
package soc_system_dipsw_debounce_pio_pkg;

  // Avalon word addresses of the PIO register map
  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  // Edge-capture sensitivity encodings
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int PIO_BUS_W = 32;

  // Reduce a rise/fall pulse pair to the single pulse that edge capture sees.
  function automatic logic edge_select(input int edge_type, input logic rise, input logic fall);
    logic sel;
    sel = 1'b0;
    case (edge_type)
      EDGE_RISING:  sel = rise;
      EDGE_FALLING: sel = fall;
      default:      sel = rise | fall;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/soc_system_dipsw_debounce_pio_if.sv
// Avalon-MM slave bus of the DIP-switch PIO (zero wait states).
// Handshake: a write is accepted on any clock edge where chipselect=1 and
// write_n=0; there is no waitrequest. readdata is a combinational function of
// address and the registers and is valid in the same cycle; reads have no
// side effects.
interface soc_system_dipsw_debounce_pio_if;
  import soc_system_dipsw_debounce_pio_pkg::*;

  logic [1:0]           address;
  logic                 chipselect;
  logic                 write_n;
  logic [PIO_BUS_W-1:0] writedata;
  logic [PIO_BUS_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_dipsw_debounce_pio_debounce_bit.sv
// One switch input: 2-FF synchroniser, hold counter and accepted (stable)
// level. rise/fall are single-cycle pulses registered alongside the stable
// update, so they are high during the cycle right after stable changes.
module soc_system_debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          q1;
  logic          q2;
  logic          sync;
  logic [CW-1:0] cnt;

  assign sync = q2;

  // Two-stage synchroniser for the asynchronous switch level
  always_ff @(posedge clk) begin
    if (reset) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= raw;
      q2 <= q1;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level on the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      stable <= RESET_BIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // acceptance clears the counter, so it never wraps
        stable <= sync;
        cnt    <= '0;
        rise   <= sync;
        fall   <= ~sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/soc_system_dipsw_debounce_pio.sv
// DIP-switch input PIO: debounced levels on DATA, maskable edge capture with a
// registered level interrupt to the HPS.
module soc_system_dipsw_debounce_pio
  import soc_system_dipsw_debounce_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  soc_system_dipsw_debounce_pio_if.slave   bus,
  input  logic [WIDTH-1:0]                 in_port,
  output logic                             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] cap_clear;
  logic             wr_en;
  logic             unused_writedata;

  assign unused_writedata = &{1'b0, bus.writedata};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    soc_system_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_BIT       (RESET_VALUE[i])
    ) u_debounce (
      .clk    (clk),
      .reset  (reset),
      .raw    (in_port[i]),
      .stable (stable[i]),
      .rise   (rise[i]),
      .fall   (fall[i])
    );
  end

  assign wr_en = bus.chipselect & ~bus.write_n;

  // Qualify debounced edges by the configured sensitivity
  always_comb begin
    edge_pulse = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_pulse[i] = edge_select(EDGE_TYPE, rise[i], fall[i]);
    end
  end

  // Write-1-to-clear mask for the edge capture register
  always_comb begin
    cap_clear = '0;
    if (wr_en && (bus.address == PIO_ADDR_EDGECAP)) begin
      cap_clear = bus.writedata[WIDTH-1:0];
    end
  end

  // Mask register, edge capture (set beats clear) and registered interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_mask <= '0;
      edge_cap <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && (bus.address == PIO_ADDR_IRQMASK)) begin
        irq_mask <= bus.writedata[WIDTH-1:0];
      end
      edge_cap <= (edge_cap & ~cap_clear) | edge_pulse;
      irq      <= |(edge_cap & irq_mask);
    end
  end

  // Zero-wait-state read mux; unused bits and the reserved word read 0
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      PIO_ADDR_DATA:    bus.readdata[WIDTH-1:0] = stable;
      PIO_ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = irq_mask;
      PIO_ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edge_cap;
      default:          bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_dipsw_debounce_pio.sv
// Bench for the DIP-switch PIO. Two instances share one stimulus stream:
// dut_a captures any edge with reset level 0x0, dut_b captures rising edges
// with reset level 0x2.
module tb_soc_system_dipsw_debounce_pio;
  import soc_system_dipsw_debounce_pio_pkg::*;

  localparam int W = 4;
  localparam int D = 4;
  localparam logic [W-1:0] RV_A = 4'h0;
  localparam logic [W-1:0] RV_B = 4'h2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   address    = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [31:0]  writedata  = 32'h0;
  logic [W-1:0] in_port    = '0;
  logic         irq_a;
  logic         irq_b;

  soc_system_dipsw_debounce_pio_if bus_a ();
  soc_system_dipsw_debounce_pio_if bus_b ();

  assign bus_a.address    = address;
  assign bus_a.chipselect = chipselect;
  assign bus_a.write_n    = write_n;
  assign bus_a.writedata  = writedata;
  assign bus_b.address    = address;
  assign bus_b.chipselect = chipselect;
  assign bus_b.write_n    = write_n;
  assign bus_b.writedata  = writedata;

  soc_system_dipsw_debounce_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_ANY), .RESET_VALUE(RV_A)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .in_port(in_port), .irq(irq_a)
  );

  soc_system_dipsw_debounce_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_RISING), .RESET_VALUE(RV_B)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .in_port(in_port), .irq(irq_b)
  );

  int vectors = 0;
  int errors  = 0;

  // ---------------- behavioural model ----------------
  // A level is accepted once the synchronised input has disagreed with the
  // accepted level for D consecutive cycles since reset; history window below.
  logic [W-1:0] m_stable [2];
  logic [W-1:0] m_cap    [2];
  logic [W-1:0] m_pulse  [2];
  logic         m_irq    [2];
  logic [W-1:0] m_mask;
  logic [W-1:0] m_d1, m_d2;
  logic [W-1:0] hist [$];
  int           m_et [2] = '{EDGE_ANY, EDGE_RISING};
  logic [W-1:0] m_rv [2] = '{RV_A, RV_B};
  bit           model_ok = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] sync_v;
    logic [W-1:0] clr;
    logic [W-1:0] pulse_n;
    logic         irq_n;
    bit           all_diff;
    bit           rising;
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        m_stable[m] = m_rv[m];
        m_cap[m]    = '0;
        m_pulse[m]  = '0;
        m_irq[m]    = 1'b0;
      end
      m_mask = '0;
      m_d1 = '0;
      m_d2 = '0;
      hist.delete();
      model_ok = 1'b1;
    end else begin
      sync_v = m_d2;
      m_d2 = m_d1;
      m_d1 = in_port;
      hist.push_back(sync_v);
      if (hist.size() > D) void'(hist.pop_front());
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int m = 0; m < 2; m++) begin
        irq_n = |(m_cap[m] & m_mask);
        m_cap[m] = (m_cap[m] & ~clr) | m_pulse[m];
        m_irq[m] = irq_n;
        pulse_n = '0;
        for (int b = 0; b < W; b++) begin
          if (hist.size() == D) begin
            all_diff = 1'b1;
            foreach (hist[j]) if (hist[j][b] == m_stable[m][b]) all_diff = 1'b0;
            if (all_diff) begin
              m_stable[m][b] = ~m_stable[m][b];
              rising = m_stable[m][b];
              if (m_et[m] == EDGE_ANY || (m_et[m] == EDGE_RISING && rising) ||
                  (m_et[m] == EDGE_FALLING && !rising))
                pulse_n[b] = 1'b1;
            end
          end
        end
        m_pulse[m] = pulse_n;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    logic        got_irq;
    if (model_ok) begin
      for (int m = 0; m < 2; m++) begin
        exp_rd = 32'h0;
        case (address)
          2'd0:    exp_rd[W-1:0] = m_stable[m];
          2'd2:    exp_rd[W-1:0] = m_mask;
          2'd3:    exp_rd[W-1:0] = m_cap[m];
          default: exp_rd = 32'h0;
        endcase
        got_rd  = (m == 0) ? bus_a.readdata : bus_b.readdata;
        got_irq = (m == 0) ? irq_a : irq_b;
        vectors++;
        if (got_rd !== exp_rd) begin
          errors++;
          $display("FAIL model_rd dut%0d addr %0d t=%0t: got 0x%0h expected 0x%0h",
                   m, address, $time, got_rd, exp_rd);
        end
        vectors++;
        if (got_irq !== m_irq[m]) begin
          errors++;
          $display("FAIL model_irq dut%0d t=%0t: got %0b expected %0b",
                   m, $time, got_irq, m_irq[m]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // reset state
    rd(2'd0); check("rst_data_a", bus_a.readdata, 32'h0); check("rst_data_b", bus_b.readdata, 32'h2);
    rd(2'd1); check("rst_rsvd_a", bus_a.readdata, 32'h0);
    tick(1);
    rd(2'd2); check("rst_mask_a", bus_a.readdata, 32'h0);
    rd(2'd3); check("rst_cap_a", bus_a.readdata, 32'h0);
    check("rst_irq_a", {31'h0, irq_a}, 32'h0);
    tick(10);

    // clean step 0x0 -> 0x5: DATA changes on the 6th edge, not the 5th
    in_port = 4'h5;
    tick(5); rd(2'd0); check("step_data_5cyc", bus_a.readdata, 32'h0);
    tick(1); rd(2'd0); check("step_data_6cyc", bus_a.readdata, 32'h5);
    tick(1); rd(2'd3); check("step_cap_a", bus_a.readdata, 32'h5);
    check("step_cap_b", bus_b.readdata, 32'h5);

    // 3-cycle glitch on bit1 is rejected
    wr(2'd3, 32'hF);
    in_port = 4'h7;
    tick(3);
    in_port = 4'h5;
    tick(10);
    rd(2'd0); check("glitch_data", bus_a.readdata, 32'h5);
    rd(2'd3); check("glitch_cap", bus_a.readdata, 32'h0);
    check("glitch_irq", {31'h0, irq_a}, 32'h0);

    // masked interrupt on bit2
    in_port = 4'h1;
    tick(10);
    wr(2'd3, 32'hF);
    wr(2'd2, 32'h4);
    in_port = 4'h5;
    tick(7);
    rd(2'd3); check("irq_cap_set", bus_a.readdata, 32'h4);
    check("irq_not_yet", {31'h0, irq_a}, 32'h0);
    tick(1); check("irq_asserted", {31'h0, irq_a}, 32'h1);
    wr(2'd3, 32'h4);
    rd(2'd3); check("irq_cap_cleared", bus_a.readdata, 32'h0);
    tick(1); check("irq_deasserted", {31'h0, irq_a}, 32'h0);

    // clear and edge set of bit0 in the same cycle: set wins
    in_port = 4'h4;
    tick(6);
    wr(2'd3, 32'h1);
    rd(2'd3); check("set_wins_cap", bus_a.readdata, 32'h1);
    check("set_wins_irq", {31'h0, irq_a}, 32'h0);

    // rising-only capture on dut_b, bit3
    wr(2'd3, 32'hF);
    in_port = 4'hC;
    tick(8);
    rd(2'd3); check("b3_rise1_a", bus_a.readdata, 32'h8); check("b3_rise1_b", bus_b.readdata, 32'h8);
    wr(2'd3, 32'hF);
    in_port = 4'h4;
    tick(8);
    rd(2'd3); check("b3_fall_a", bus_a.readdata, 32'h8); check("b3_fall_b", bus_b.readdata, 32'h0);
    wr(2'd3, 32'hF);
    in_port = 4'hC;
    tick(8);
    rd(2'd3); check("b3_rise2_b", bus_b.readdata, 32'h8);

    // reset mid-count discards partial debounce state
    in_port = 4'h5;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd(2'd0); check("midrst_data_a", bus_a.readdata, 32'h0); check("midrst_data_b", bus_b.readdata, 32'h2);
    tick(5); rd(2'd0); check("midrst_5cyc_a", bus_a.readdata, 32'h0);
    tick(1); rd(2'd0); check("midrst_6cyc_a", bus_a.readdata, 32'h5);
    check("midrst_6cyc_b", bus_b.readdata, 32'h5);
    tick(1); rd(2'd3); check("midrst_cap_a", bus_a.readdata, 32'h5);
    check("midrst_cap_b", bus_b.readdata, 32'h5);
    rd(2'd2); check("midrst_mask_a", bus_a.readdata, 32'h0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
